// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, master instruction codes and bit-level constants.
package i2c_pkg;

    localparam int unsigned ByteW = 8;
    localparam int unsigned AddrW = 7;
    localparam int unsigned CntW  = 4;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } tgt_state_e;

    typedef enum logic [2:0] {
        INST_NOP,
        INST_START,
        INST_WRITE,
        INST_READ_ACK,
        INST_READ_NACK,
        INST_STOP
    } inst_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes an asynchronous pad input and reports its registered level and edges.
module i2c_sync_edge #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  hist_q;
    logic                  level_q;
    logic                  rise_q;
    logic                  fall_q;

    // Reset to the idle-bus level so no false edge is seen after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            hist_q  <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncStages-2:0], d_i};
            hist_q  <= sync_q[SyncStages-1];
            level_q <= sync_q[SyncStages-1];
            rise_q  <= sync_q[SyncStages-1] & ~hist_q;
            fall_q  <= ~sync_q[SyncStages-1] & hist_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register-pointer interface: first written byte sets the
// pointer, later written bytes are register writes, reads stream from the pointer.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [AddrW-1:0] TargetAddr = 7'h3C,
    parameter int unsigned      SyncStages = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic [ByteW-1:0] reg_addr_o,
    output logic [ByteW-1:0] reg_wdata_o,
    output logic             reg_we_o,
    output logic             reg_re_o,
    input  logic [ByteW-1:0] reg_rdata_i,
    output logic             busy_o
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SyncStages(SyncStages)) u_scl_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SyncStages(SyncStages)) u_sda_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic bus_start, bus_stop;
    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    tgt_state_e       state_q;
    logic [CntW-1:0]  bit_cnt_q;
    logic [ByteW-1:0] shift_q;
    logic [ByteW-1:0] ptr_q;
    logic [ByteW-1:0] wdata_q;
    logic             first_q;
    logic             rw_q;
    logic             ack_drv_q;
    logic             sda_q;
    logic             busy_q;
    logic             we_q;
    logic             re_q;
    logic             lat_q;

    logic [ByteW-1:0] shift_in;
    assign shift_in = {shift_q[ByteW-2:0], sda_lvl};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            wdata_q   <= '0;
            first_q   <= 1'b0;
            rw_q      <= 1'b0;
            ack_drv_q <= 1'b0;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            lat_q     <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            re_q  <= 1'b0;
            lat_q <= re_q;

            // Read data arrives the cycle after the strobe; capture it one cycle later.
            if (lat_q) begin
                shift_q <= reg_rdata_i;
                ptr_q   <= ptr_q + ByteW'(1);
            end
            if (we_q) begin
                ptr_q <= ptr_q + ByteW'(1);
            end

            if (bus_start) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= '0;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
            end else if (bus_stop) begin
                state_q   <= ST_IDLE;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_q <= 1'b1;
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                            if (bit_cnt_q == CntW'(7)) begin
                                if (shift_in[ByteW-1:1] == TargetAddr) begin
                                    rw_q      <= shift_in[0];
                                    busy_q    <= 1'b1;
                                    ack_drv_q <= 1'b0;
                                    state_q   <= ST_ADDR_ACK;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end
                        end
                    end

                    // First fall drives ACK, second fall ends the ACK clock.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_q) begin
                                sda_q     <= I2C_ACK;
                                ack_drv_q <= 1'b1;
                            end else begin
                                ack_drv_q <= 1'b0;
                                if (rw_q) begin
                                    sda_q     <= shift_q[ByteW-1];
                                    shift_q   <= {shift_q[ByteW-2:0], 1'b0};
                                    bit_cnt_q <= CntW'(1);
                                    state_q   <= ST_RD_BYTE;
                                end else begin
                                    sda_q     <= 1'b1;
                                    bit_cnt_q <= '0;
                                    first_q   <= 1'b1;
                                    state_q   <= ST_WR_BYTE;
                                end
                            end
                        end else if (scl_rise && ack_drv_q && rw_q) begin
                            re_q <= 1'b1;
                        end
                    end

                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                            if (bit_cnt_q == CntW'(7)) begin
                                if (first_q) begin
                                    ptr_q   <= shift_in;
                                    first_q <= 1'b0;
                                end else begin
                                    we_q    <= 1'b1;
                                    wdata_q <= shift_in;
                                end
                                ack_drv_q <= 1'b0;
                                state_q   <= ST_WR_ACK;
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_q) begin
                                sda_q     <= I2C_ACK;
                                ack_drv_q <= 1'b1;
                            end else begin
                                sda_q     <= 1'b1;
                                ack_drv_q <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= ST_WR_BYTE;
                            end
                        end
                    end

                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == CntW'(8)) begin
                                sda_q     <= 1'b1;
                                ack_drv_q <= 1'b0;
                                state_q   <= ST_RD_ACK;
                            end else begin
                                sda_q     <= shift_q[ByteW-1];
                                shift_q   <= {shift_q[ByteW-2:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                            end
                        end
                    end

                    // ack_drv_q here records that the master acknowledged the byte.
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == I2C_ACK) begin
                                re_q      <= 1'b1;
                                ack_drv_q <= 1'b1;
                            end else begin
                                sda_q   <= I2C_NACK;
                                busy_q  <= 1'b0;
                                state_q <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && ack_drv_q) begin
                            sda_q     <= shift_q[ByteW-1];
                            shift_q   <= {shift_q[ByteW-2:0], 1'b0};
                            bit_cnt_q <= CntW'(1);
                            ack_drv_q <= 1'b0;
                            state_q   <= ST_RD_BYTE;
                        end
                    end

                    default: begin
                        sda_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_o       = sda_q;
    assign busy_o      = busy_q;
    assign reg_addr_o  = ptr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;

endmodule
